// File: rtl/s2p_converter_pkg.sv
// Shared types and constants for the 1-Wire serial-to-parallel converter.
// The CRC option is enabled with the S2P_CRC8_EN macro in the top module.
package s2p_converter_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] ONEWIRE_CRC8_POLY = 8'h8C;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/onewire_crc8.sv
// Single-bit step of the Dallas/Maxim reflected CRC-8 (x^8+x^5+x^4+1).
// Used by s2p_converter only when S2P_CRC8_EN is defined.
module onewire_crc8
    import s2p_converter_pkg::*;
(
    input  logic [BYTE_W-1:0] crc_i,
    input  logic              bit_i,
    output logic [BYTE_W-1:0] crc_o
);

    logic feedback;

    assign feedback = crc_i[0] ^ bit_i;
    assign crc_o    = (crc_i >> 1) ^ (feedback ? ONEWIRE_CRC8_POLY : '0);

endmodule

// File: rtl/s2p_converter.sv
// Collects 1-Wire bits LSB-first into bytes with a valid/ready output and an idle timeout.
// Define S2P_CRC8_EN to add the running CRC-8 outputs crc_out/crc_ok.
module s2p_converter
    import s2p_converter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              frame_start,
    output logic [BYTE_W-1:0] data_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [2:0]        bit_count,
    output logic              overrun,
    output logic              timeout_err
`ifdef S2P_CRC8_EN
    ,
    output logic [BYTE_W-1:0] crc_out,
    output logic              crc_ok
`endif
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] shiftReg_q, shiftReg_d;
    logic [2:0]        bitCnt_q, bitCnt_d;
    logic [15:0]       idleCnt_q, idleCnt_d;
    logic [BYTE_W-1:0] dataOut_q, dataOut_d;
    logic              byteValid_q, byteValid_d;
    logic              overrun_q, overrun_d;
    logic              timeoutErr_q, timeoutErr_d;

    logic [BYTE_W-1:0] shiftBase;
    logic [2:0]        cntBase;
    logic [BYTE_W-1:0] newByte;
    logic              byteDone;
    logic              handshake;
    logic              timeoutHit;

    // frame_start clears the partial byte before a same-cycle bit is shifted in
    always_comb begin
        shiftBase  = frame_start ? '0 : shiftReg_q;
        cntBase    = frame_start ? 3'd0 : bitCnt_q;
        newByte    = {bit_in, shiftBase[BYTE_W-1:1]};
        byteDone   = bit_valid && (cntBase == 3'd7);
        handshake  = byteValid_q && byte_ready;
        timeoutHit = (state_q == SHIFT) && !bit_valid && !frame_start
                     && (idleCnt_q == TIMEOUT_LIM - 16'd1);
    end

    always_comb begin
        state_d      = frame_start ? IDLE : state_q;
        shiftReg_d   = shiftBase;
        bitCnt_d     = cntBase;
        idleCnt_d    = '0;
        timeoutErr_d = 1'b0;
        if (bit_valid) begin
            if (byteDone) begin
                shiftReg_d = '0;
                bitCnt_d   = 3'd0;
                state_d    = IDLE;
            end else begin
                shiftReg_d = newByte;
                bitCnt_d   = cntBase + 3'd1;
                state_d    = SHIFT;
            end
        end else if (timeoutHit) begin
            shiftReg_d   = '0;
            bitCnt_d     = 3'd0;
            state_d      = IDLE;
            timeoutErr_d = 1'b1;
        end else if (state_d == SHIFT) begin
            idleCnt_d = idleCnt_q + 16'd1;
        end
    end

    // A finished byte is dropped only when the previous one is still pending and not consumed now
    always_comb begin
        dataOut_d   = dataOut_q;
        byteValid_d = byteValid_q;
        overrun_d   = frame_start ? 1'b0 : overrun_q;
        if (handshake) begin
            byteValid_d = 1'b0;
        end
        if (byteDone) begin
            if (!byteValid_q || handshake) begin
                dataOut_d   = newByte;
                byteValid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shiftReg_q   <= '0;
            bitCnt_q     <= '0;
            idleCnt_q    <= '0;
            dataOut_q    <= '0;
            byteValid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shiftReg_q   <= shiftReg_d;
            bitCnt_q     <= bitCnt_d;
            idleCnt_q    <= idleCnt_d;
            dataOut_q    <= dataOut_d;
            byteValid_q  <= byteValid_d;
            overrun_q    <= overrun_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign data_out    = dataOut_q;
    assign byte_valid  = byteValid_q;
    assign bit_count   = bitCnt_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeoutErr_q;

`ifdef S2P_CRC8_EN
    logic [BYTE_W-1:0] crc_q, crc_d;
    logic [BYTE_W-1:0] crcBase, crcNext;
    logic              crcOk_q, crcOk_d;

    onewire_crc8 u_crc8 (
        .crc_i (crcBase),
        .bit_i (bit_in),
        .crc_o (crcNext)
    );

    // The CRC runs across the whole frame; crc_ok is refreshed at each byte boundary
    always_comb begin
        crcBase = frame_start ? '0 : crc_q;
        crc_d   = bit_valid ? crcNext : crcBase;
        crcOk_d = frame_start ? 1'b0 : crcOk_q;
        if (byteDone) begin
            crcOk_d = (crcNext == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q   <= '0;
            crcOk_q <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            crcOk_q <= crcOk_d;
        end
    end

    assign crc_out = crc_q;
    assign crc_ok  = crcOk_q;
`endif

endmodule
